// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, FSM states, bounce
// direction and the per-mode start pattern.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned MAX_LED_W = 32;

    // Returned at full width; callers cast down to their LED_W.
    function automatic logic [MAX_LED_W-1:0] start_pattern(input mode_e m);
        logic [MAX_LED_W-1:0] pat;
        pat = '0;
        if (m == MODE_SHIFT || m == MODE_BOUNCE) begin
            pat[0] = 1'b1;
        end
        return pat;
    endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Reloadable up-counter that pulses tick combinationally while run is high and
// the count sits at all-ones; the count then reloads INIT on the following edge.
module tick_prescaler #(
    parameter int unsigned    W    = 24,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic reload,
    output logic tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = run & (&cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = INIT;
        end else if (run) begin
            cnt_d = tick ? INIT : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: FSM, pending-mode register and pattern datapath.
// led/active_mode are registered and change on the edge ending a tick cycle.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned             PRESCALE_W    = 24,
    parameter logic [PRESCALE_W-1:0]   PRESCALE_INIT = '0,
    parameter int unsigned             LED_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             mode_stb,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic [1:0]       active_mode
);

    state_e            state_q;
    logic [LED_W-1:0]  led_q;
    mode_e             active_q;
    mode_e             pend_q;
    logic              pend_vld_q;
    logic              dir_q;

    logic              run;
    logic              reload;
    mode_e             next_mode;
    logic [LED_W-1:0]  start_led;
    logic [LED_W-1:0]  led_adv_d;
    logic              dir_d;

    assign run    = ~rst & en & (state_q == ST_RUN);
    assign reload = (state_q == ST_LOAD);

    tick_prescaler #(
        .W    (PRESCALE_W),
        .INIT (PRESCALE_INIT)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .reload (reload),
        .tick   (tick)
    );

    // Both LOAD and a tick with a pending request start the same pattern.
    assign next_mode = pend_vld_q ? pend_q : active_q;
    assign start_led = LED_W'(start_pattern(next_mode));

    always_comb begin
        led_adv_d = led_q;
        dir_d     = dir_q;
        unique case (active_q)
            MODE_BLINK:  led_adv_d = ~led_q;
            MODE_COUNT:  led_adv_d = led_q + LED_W'(1);
            MODE_SHIFT:  led_adv_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    if (led_q[LED_W-1]) begin
                        led_adv_d = led_q >> 1;
                        dir_d     = DIR_RIGHT;
                    end else begin
                        led_adv_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_adv_d = led_q << 1;
                        dir_d     = DIR_LEFT;
                    end else begin
                        led_adv_d = led_q >> 1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            active_q   <= MODE_BLINK;
            pend_q     <= MODE_BLINK;
            pend_vld_q <= 1'b0;
            dir_q      <= DIR_LEFT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    led_q <= '0;
                    if (en) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    active_q   <= next_mode;
                    pend_vld_q <= 1'b0;
                    led_q      <= start_led;
                    dir_q      <= DIR_LEFT;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        state_q <= ST_PAUSE;
                    end else if (tick) begin
                        if (pend_vld_q) begin
                            active_q   <= pend_q;
                            led_q      <= start_led;
                            dir_q      <= DIR_LEFT;
                            pend_vld_q <= 1'b0;
                        end else begin
                            led_q <= led_adv_d;
                            dir_q <= dir_d;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (en) state_q <= ST_RUN;
                end
            endcase
            // A strobe coinciding with a consuming tick stays pending for the next one.
            if (mode_stb) begin
                pend_q     <= mode_e'(mode);
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign led         = led_q;
    assign active_mode = active_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer against a step-index pattern model.
module tb_led_sequencer;

    localparam int LW     = 4;
    localparam int PERIOD = 6;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          mode_stb;
    logic [LW-1:0] led;
    logic          tick;
    logic [1:0]    active_mode;

    int n_vec = 0;
    int n_bad = 0;

    int m_st    = M_IDLE;
    int m_amode = 0;
    int m_k     = 0;
    int m_phase = 0;
    int m_pend  = 0;
    bit m_pv    = 1'b0;

    led_sequencer #(
        .PRESCALE_W    (24),
        .PRESCALE_INIT (24'hFFFFFA),
        .LED_W         (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .mode_stb    (mode_stb),
        .led         (led),
        .tick        (tick),
        .active_mode (active_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LED value after k advances of a pattern that started at its start value.
    function automatic logic [LW-1:0] pat(input int md, input int k);
        int p;
        p = k % (2 * LW - 2);
        case (md)
            0:       return (k % 2 == 1) ? {LW{1'b1}} : {LW{1'b0}};
            1:       return LW'(k % (1 << LW));
            2:       return LW'(1 << (k % LW));
            default: return LW'(1 << ((p < LW) ? p : (2 * LW - 2 - p)));
        endcase
    endfunction

    function automatic logic [LW-1:0] exp_led();
        if (m_st == M_IDLE || m_st == M_LOAD) return '0;
        return pat(m_amode, m_k);
    endfunction

    task automatic cyc(input bit r, input bit e, input bit [1:0] m, input bit s);
        bit et;
        rst = r; en = e; mode = m; mode_stb = s;
        #1;
        et = !r && (m_st == M_RUN) && e && (m_phase == PERIOD - 1);
        chk("tick", 32'(tick), 32'(et));
        @(posedge clk);
        if (r) begin
            m_st = M_IDLE; m_amode = 0; m_k = 0; m_phase = 0; m_pend = 0; m_pv = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (e) m_st = M_LOAD;
                M_LOAD: begin
                    if (m_pv) m_amode = m_pend;
                    m_pv = 1'b0; m_k = 0; m_phase = 0; m_st = M_RUN;
                end
                M_RUN: begin
                    if (!e) begin
                        m_st = M_PAUSE;
                    end else begin
                        if (et) begin
                            if (m_pv) begin
                                m_amode = m_pend; m_k = 0; m_pv = 1'b0;
                            end else begin
                                m_k++;
                            end
                        end
                        m_phase = (m_phase + 1) % PERIOD;
                    end
                end
                default: if (e) m_st = M_RUN;
            endcase
            if (s) begin
                m_pend = int'(m); m_pv = 1'b1;
            end
        end
        @(negedge clk);
        chk("led", 32'(led), 32'(exp_led()));
        chk("active_mode", 32'(active_mode), 32'(m_amode));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd0, 1'b0);
        run_cycles(20);

        cyc(1'b0, 1'b1, 2'd2, 1'b1);
        run_cycles(32);

        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        run_cycles(45);

        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        run_cycles(PERIOD * 18);

        run_cycles(3);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        run_cycles(20);

        for (int i = 0; i < PERIOD + 2 && !(m_st == M_RUN && m_phase == PERIOD - 1); i++)
            cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 1'b1);
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        run_cycles(14);
        cyc(1'b1, 1'b1, 2'd0, 1'b0);
        run_cycles(10);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 10) != 0,
                2'($urandom % 4), ($urandom % 12) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
